// File: rtl/regfile_mp_sb_if.sv
// Operand-read, reserve and writeback bus of the regfile_mp_sb scoreboarded register file.
interface regfile_mp_sb_if #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD         = 3
);
  logic [NUM_RD*REG_ADDR_WIDTH-1:0] Rd_Sel_i;
  logic [NUM_RD*REG_WIDTH-1:0]      Rd_Data_o;
  logic [NUM_RD-1:0]                Rd_Busy_o;
  logic                             Rsv_Valid_i;
  logic [REG_ADDR_WIDTH-1:0]        Rsv_Sel_i;
  logic                             Wr_We_i;
  logic [REG_ADDR_WIDTH-1:0]        Wr_Sel_i;
  logic [REG_WIDTH-1:0]             Wr_Data_i;
  logic                             Flush_i;
  logic [REG_ADDR_WIDTH:0]          Busy_Cnt_o;

  modport master (
    output Rd_Sel_i, Rsv_Valid_i, Rsv_Sel_i, Wr_We_i, Wr_Sel_i, Wr_Data_i, Flush_i,
    input  Rd_Data_o, Rd_Busy_o, Busy_Cnt_o
  );

  modport slave (
    input  Rd_Sel_i, Rsv_Valid_i, Rsv_Sel_i, Wr_We_i, Wr_Sel_i, Wr_Data_i, Flush_i,
    output Rd_Data_o, Rd_Busy_o, Busy_Cnt_o
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with busy-bit scoreboard and busy counter.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD         = 3,
  parameter int unsigned R0_IS_ZERO     = 1
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  regfile_mp_sb_if.slave    bus
);
  localparam int unsigned W         = REG_WIDTH;
  localparam int unsigned AW        = REG_ADDR_WIDTH;
  localparam int unsigned CW        = REG_ADDR_WIDTH + 1;
  localparam int unsigned REG_COUNT = 2 ** REG_ADDR_WIDTH;

  logic [W-1:0]         regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 wr_ok;
  logic                 rsv_ok;
  logic                 set_bit;
  logic                 clr_bit;

  always_comb begin
    wr_ok  = bus.Wr_We_i && !((R0_IS_ZERO != 0) && (bus.Wr_Sel_i == '0));
    rsv_ok = bus.Rsv_Valid_i && !bus.Flush_i &&
             !((R0_IS_ZERO != 0) && (bus.Rsv_Sel_i == '0));
    // A write only frees a slot when a younger reserve isn't re-claiming it.
    set_bit = rsv_ok && !busy[bus.Rsv_Sel_i];
    clr_bit = wr_ok && busy[bus.Wr_Sel_i] &&
              !(rsv_ok && (bus.Rsv_Sel_i == bus.Wr_Sel_i));

    busy_nxt = busy;
    if (wr_ok)  busy_nxt[bus.Wr_Sel_i]  = 1'b0;
    if (rsv_ok) busy_nxt[bus.Rsv_Sel_i] = 1'b1;
    if (bus.Flush_i) busy_nxt = '0;

    if (bus.Flush_i) cnt_nxt = '0;
    else             cnt_nxt = cnt + CW'(set_bit) - CW'(clr_bit);
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) regs[bus.Wr_Sel_i] <= bus.Wr_Data_i;
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    bus.Rd_Data_o = '0;
    bus.Rd_Busy_o = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin : rd_port
      logic [AW-1:0] s;
      s = bus.Rd_Sel_i[k*AW +: AW];
      bus.Rd_Data_o[k*W +: W] = regs[s];
      bus.Rd_Busy_o[k]        = busy[s];
      if ((R0_IS_ZERO != 0) && (s == '0)) begin
        bus.Rd_Data_o[k*W +: W] = '0;
        bus.Rd_Busy_o[k]        = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      // wr_ok already excludes reg 0, so the zero register is never bypassed.
      if (wr_ok && (s == bus.Wr_Sel_i)) begin
        bus.Rd_Data_o[k*W +: W] = bus.Wr_Data_i;
        bus.Rd_Busy_o[k]        = bus.Rsv_Valid_i && (bus.Rsv_Sel_i == bus.Wr_Sel_i);
      end
`else
      // Without bypass, written data only becomes visible after the edge.
`endif
    end
  end

  assign bus.Busy_Cnt_o = cnt;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table, corner sequences, random vs model.
module tb_regfile_mp_sb;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;
  localparam int unsigned RC = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_mp_sb_if #(.REG_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

  regfile_mp_sb #(
    .REG_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .R0_IS_ZERO(1)
  ) dut (
    .Clk_i(clk),
    .Rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] m_regs [RC];
  logic         m_busy [RC];

  typedef struct {
    logic          rv;
    logic [AW-1:0] rs;
    logic          we;
    logic [AW-1:0] ws;
    logic [W-1:0]  wd;
    logic          fl;
    logic [NR*AW-1:0] rsel;
    logic [NR*W-1:0]  edata;
    logic [NR-1:0]    ebusy;
    logic [AW:0]      ecnt;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic rv, input logic [AW-1:0] rs, input logic we,
                              input logic [AW-1:0] ws, input logic [W-1:0] wd, input logic fl,
                              input logic [AW-1:0] s2, input logic [AW-1:0] s1,
                              input logic [AW-1:0] s0, input logic [W-1:0] d2,
                              input logic [W-1:0] d1, input logic [W-1:0] d0,
                              input logic [NR-1:0] eb, input logic [AW:0] ec);
    vec_t v;
    v.rv = rv; v.rs = rs; v.we = we; v.ws = ws; v.wd = wd; v.fl = fl;
    v.rsel = {s2, s1, s0};
    v.edata = {d2, d1, d0};
    v.ebusy = eb;
    v.ecnt = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [AW-1:0] rs, input logic we,
                       input logic [AW-1:0] ws, input logic [W-1:0] wd, input logic fl);
    bus.Rsv_Valid_i = rv;
    bus.Rsv_Sel_i   = rs;
    bus.Wr_We_i     = we;
    bus.Wr_Sel_i    = ws;
    bus.Wr_Data_i   = wd;
    bus.Flush_i     = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(RC); i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < int'(RC); i++) if (m_busy[i]) n++;
    return n;
  endfunction

  // Advance one clock edge; the reference model follows the architectural rules.
  task automatic tick();
    logic rv, we, fl;
    logic [AW-1:0] rs, ws;
    logic [W-1:0] wd;
    rv = bus.Rsv_Valid_i; rs = bus.Rsv_Sel_i;
    we = bus.Wr_We_i; ws = bus.Wr_Sel_i; wd = bus.Wr_Data_i; fl = bus.Flush_i;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (we && ws != 0) m_regs[ws] = wd;
      if (fl) begin
        for (int i = 0; i < int'(RC); i++) m_busy[i] = 1'b0;
      end else begin
        if (we && ws != 0) m_busy[ws] = 1'b0;
        if (rv && rs != 0) m_busy[rs] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic exp_rd(input logic [AW-1:0] s, output logic [W-1:0] d, output logic b);
    d = (s == 0) ? '0 : m_regs[s];
    b = (s == 0) ? 1'b0 : m_busy[s];
`ifdef REGFILE_BYPASS_EN
    if (bus.Wr_We_i && bus.Wr_Sel_i == s && s != 0) begin
      d = bus.Wr_Data_i;
      b = bus.Rsv_Valid_i && (bus.Rsv_Sel_i == bus.Wr_Sel_i);
    end
`endif
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] d;
    logic b;
    for (int k = 0; k < int'(NR); k++) begin
      exp_rd(bus.Rd_Sel_i[k*AW +: AW], d, b);
      check($sformatf("%s data%0d", tag, k), 64'(bus.Rd_Data_o[k*W +: W]), 64'(d));
      check($sformatf("%s busy%0d", tag, k), 64'(bus.Rd_Busy_o[k]), 64'(b));
    end
    check($sformatf("%s cnt", tag), 64'(bus.Busy_Cnt_o), 64'(model_count()));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    rst = 1'b1;
    idle();
    bus.Rd_Sel_i = {5'd9, 5'd7, 5'd5};
    #12;
    check("reset data", 64'(bus.Rd_Data_o), 64'd0);
    check("reset busy", 64'(bus.Rd_Busy_o), 64'd0);
    check("reset cnt", 64'(bus.Busy_Cnt_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vt[0]  = mk(1, 5,  0, 0,  32'h0,        0, 0, 0, 5,  0, 0, 0,            3'b001, 6'd1);
    vt[1]  = mk(0, 0,  1, 5,  32'hDEADBEEF, 0, 0, 0, 5,  0, 0, 32'hDEADBEEF, 3'b000, 6'd0);
    vt[2]  = mk(1, 7,  0, 0,  32'h0,        0, 0, 5, 7,  0, 32'hDEADBEEF, 0, 3'b001, 6'd1);
    vt[3]  = mk(1, 7,  1, 7,  32'h1234,     0, 0, 0, 7,  0, 0, 32'h1234,     3'b001, 6'd1);
    vt[4]  = mk(1, 1,  0, 0,  32'h0,        0, 3, 2, 1,  0, 0, 0,            3'b001, 6'd2);
    vt[5]  = mk(1, 2,  0, 0,  32'h0,        0, 3, 2, 1,  0, 0, 0,            3'b011, 6'd3);
    vt[6]  = mk(1, 3,  0, 0,  32'h0,        0, 3, 2, 1,  0, 0, 0,            3'b111, 6'd4);
    vt[7]  = mk(1, 4,  0, 0,  32'h0,        1, 7, 1, 4,  32'h1234, 0, 0,     3'b000, 6'd0);
    vt[8]  = mk(1, 0,  1, 0,  32'hFFFFFFFF, 0, 0, 0, 0,  0, 0, 0,            3'b000, 6'd0);
    vt[9]  = mk(1, 7,  1, 7,  32'h55,       0, 0, 0, 7,  0, 0, 32'h55,       3'b001, 6'd1);
    vt[10] = mk(0, 0,  1, 7,  32'h77,       1, 0, 0, 7,  0, 0, 32'h77,       3'b000, 6'd0);
    vt[11] = mk(1, 9,  0, 0,  32'h0,        0, 0, 0, 9,  0, 0, 0,            3'b001, 6'd1);
    vt[12] = mk(1, 9,  0, 0,  32'h0,        0, 0, 0, 9,  0, 0, 0,            3'b001, 6'd1);
    vt[13] = mk(0, 0,  1, 9,  32'hB,        0, 0, 0, 9,  0, 0, 32'hB,        3'b000, 6'd0);
    vt[14] = mk(0, 0,  1, 9,  32'hC,        0, 0, 0, 9,  0, 0, 32'hC,        3'b000, 6'd0);
    vt[15] = mk(1, 10, 0, 0,  32'h0,        0, 10, 0, 0, 0, 0, 0,            3'b100, 6'd1);
    vt[16] = mk(1, 11, 1, 10, 32'h10,       0, 11, 10, 0, 0, 32'h10, 0,      3'b100, 6'd1);
    vt[17] = mk(0, 0,  1, 11, 32'h11,       0, 11, 10, 0, 32'h11, 32'h10, 0, 3'b000, 6'd0);

    for (int i = 0; i < 18; i++) begin
      bus.Rd_Sel_i = vt[i].rsel;
      drive(vt[i].rv, vt[i].rs, vt[i].we, vt[i].ws, vt[i].wd, vt[i].fl);
      tick();
      idle();
      #1;
      check($sformatf("vec%0d data", i), 64'(bus.Rd_Data_o), 64'(vt[i].edata));
      check($sformatf("vec%0d busy", i), 64'(bus.Rd_Busy_o), 64'(vt[i].ebusy));
      check($sformatf("vec%0d cnt", i),  64'(bus.Busy_Cnt_o), 64'(vt[i].ecnt));
    end

    // Asynchronous reset mid-cycle with a reserve pending.
    drive(1'b1, 5'd5, 1'b0, '0, '0, 1'b0);
    tick();
    bus.Rd_Sel_i = {5'd9, 5'd7, 5'd5};
    #2;
    check("pre-reset busy", 64'(bus.Rd_Busy_o), 64'b001);
    rst = 1'b1;
    #1;
    check("async rst data", 64'(bus.Rd_Data_o), 64'd0);
    check("async rst busy", 64'(bus.Rd_Busy_o), 64'd0);
    check("async rst cnt", 64'(bus.Busy_Cnt_o), 64'd0);
    drive(1'b1, 5'd7, 1'b1, 5'd9, 32'hABCD, 1'b0);
    tick();
    check("rst hold data", 64'(bus.Rd_Data_o), 64'd0);
    check("rst hold cnt", 64'(bus.Busy_Cnt_o), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Same-cycle visibility of a write on read port 2.
    drive(1'b0, '0, 1'b1, 5'd9, 32'h1111, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 5'd9, 32'hA5A5, 1'b0);
    bus.Rd_Sel_i = {5'd9, 5'd0, 5'd0};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass same cycle", 64'(bus.Rd_Data_o[2*W +: W]), 64'h0000A5A5);
`else
    check("no bypass same cycle", 64'(bus.Rd_Data_o[2*W +: W]), 64'h00001111);
`endif
    tick();
    idle();
    #1;
    check("write next cycle", 64'(bus.Rd_Data_o[2*W +: W]), 64'h0000A5A5);

    // Fill every reservable register: count saturates at REG_COUNT-1.
    for (int i = 1; i < int'(RC); i++) begin
      drive(1'b1, AW'(i), 1'b0, '0, '0, 1'b0);
      tick();
    end
    idle();
    #1;
    check("full cnt", 64'(bus.Busy_Cnt_o), 64'd31);
    drive(1'b1, 5'd0, 1'b0, '0, '0, 1'b0);
    tick();
    check("full rsv x0 cnt", 64'(bus.Busy_Cnt_o), 64'd31);
    drive(1'b1, 5'd31, 1'b0, '0, '0, 1'b0);
    tick();
    check("full rsv again cnt", 64'(bus.Busy_Cnt_o), 64'd31);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    tick();
    check("flush full cnt", 64'(bus.Busy_Cnt_o), 64'd0);

    // Randomised traffic, collisions biased between reserve, write and read selects.
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] rs, ws;
      rs = AW'($urandom_range(0, 31));
      ws = ($urandom_range(0, 3) == 0) ? rs : AW'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ws, $urandom(),
            ($urandom_range(0, 15) == 0));
      for (int k = 0; k < int'(NR); k++) begin
        case ($urandom_range(0, 3))
          0: bus.Rd_Sel_i[k*AW +: AW] = ws;
          1: bus.Rd_Sel_i[k*AW +: AW] = rs;
          2: bus.Rd_Sel_i[k*AW +: AW] = '0;
          default: bus.Rd_Sel_i[k*AW +: AW] = AW'($urandom_range(0, 31));
        endcase
      end
      #1;
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
